noc_inject_arbiter: RTL
=======================

Name: noc_inject_arbiter

Overview:
- Packet-level round-robin arbiter that shares one router local injection port among NUM_REQ flit sources, e.g. several DLA-side bridges or DMA engines.
- Holds a grant from a HEAD or HEADTAIL flit until the matching TAIL or HEADTAIL flit, so flits of different packets never interleave.
- Selects the VC at packet start from the router's on/off and allocatable status, overwrites vc_id on every flit, and throttles on per-VC on/off.
- Sits between the requesters and router_data_in/router_valid_in in the clk_router domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WDOG_CYCLES, 255, stall threshold in cycles for the optional watchdog (1..65535).
- Flit type and VC_NUM come from the global include.

Ports:
- clk_router  in  1  router clock.
- rst_router  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_flit  in  NUM_REQ x flit_t  per-requester flit: flit_label, vc_id (ignored), data.
- req_ready  out  NUM_REQ  per-requester accept; a flit transfers when valid&&ready.
- router_data_in  out  flit_t  flit to the router local input.
- router_valid_in  out  1  flit valid to the router.
- router_is_on_off_out  in  VC_NUM  per-VC on/off from the router input buffer (1 = may send).
- router_is_allocatable_out  in  VC_NUM  per-VC allocatable status (1 = VC free for a new packet).
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- grant_busy  out  1  high while a packet is locked.
- pkt_done  out  1  one-cycle pulse when a tail or headtail flit is forwarded.
- wdog_err  out  1  sticky stall error; driven 0 when the optional feature is compiled out.

Behaviour:
- Reset values:
  - router_valid_in=0, router_data_in all-zero with label HEADTAIL.
  - req_ready=0, grant_id=0, grant_busy=0, pkt_done=0, wdog_err=0.
  - Internal: last_grant=NUM_REQ-1, so requester 0 wins first; vc_sel=0; state=IDLE.
- State IDLE:
  - Eligible requester: req_valid[i] and req_flit[i].flit_label is HEAD or HEADTAIL.
  - Available VC: on_off[v] && allocatable[v]; the lowest-index available VC is chosen.
  - If at least one eligible requester and one available VC exist: grant the first eligible index after last_grant (wrapping modulo NUM_REQ). Register grant_id and vc_sel, set grant_busy=1, go to XFER.
  - No flit is accepted in IDLE, so req_ready=0.
  - A valid BODY or TAIL flit in IDLE is not eligible; it is held and never granted until a head appears.
- State XFER:
  - req_ready[grant_id] = on_off[vc_sel] (combinational). All other req_ready bits = 0.
  - On transfer, next cycle: router_data_in = req_flit[grant_id] with vc_id replaced by vc_sel, and router_valid_in=1. Otherwise router_valid_in=0 and router_data_in holds its value.
  - Latency is 1 cycle from accept to router_valid_in.
  - If the transferred flit is TAIL or HEADTAIL: next cycle pkt_done=1, grant_busy=0, last_grant=grant_id, state=IDLE.
  - Any other label (BODY, or a stray HEAD) is forwarded unchanged apart from vc_id, and the state stays XFER.
- Throughput:
  - Within a packet, 1 flit/cycle when on/off stays high.
  - One arbitration cycle between packets, so single-flit packets run at 1 per 2 cycles.
- on_off[vc_sel] low mid-packet: req_ready drops the same cycle, nothing is forwarded, and the grant is held.
- allocatable is sampled only in IDLE.
- A deasserted req_valid mid-packet stalls without losing the grant.
- Reset asserted mid-packet: all state returns to the reset values immediately. A partial packet already forwarded is not completed; upstream must also be reset.
- grant_id retains its value after IDLE is re-entered until the next grant.

Optional Feature:
- Macro NOC_INJ_WDOG_EN.
- Defined:
  - A 16-bit counter increments each XFER cycle with no transfer and clears on any transfer or in IDLE.
  - When the counter reaches WDOG_CYCLES, wdog_err sets and stays set until reset.
  - Arbitration behaviour is unchanged.
- Undefined: no counter; wdog_err is tied 0.

Test Plan:
- Req0 sends HEAD+2 BODY+TAIL, on_off=2'b11, allocatable=2'b11 -> grant_id=0, vc_sel=0. Four flits appear on router_valid_in in consecutive cycles, starting 1 cycle after the first accept, all with vc_id=0. pkt_done pulses once.
- Req0..3 all present HEADTAIL continuously -> grant order 0,1,2,3,0. One flit every 2 cycles; pkt_done on each.
- Req1 mid-packet while req2 presents a head -> req2's req_ready stays 0 until req1's TAIL has been forwarded. No interleaving on router_data_in.
- on_off=2'b01 in IDLE, allocatable=2'b10 -> no grant. Changing allocatable to 2'b11 -> grant with vc_sel=0. on_off[0]=0 for 3 cycles mid-packet -> req_ready=0, router_valid_in=0 for those cycles, transfer resumes afterwards.
- Reset during BODY of req2 -> next cycle all outputs at reset values. The next grant goes to requester 0 if it is eligible.
- With NOC_INJ_WDOG_EN and WDOG_CYCLES=10: stall the granted requester for 10 cycles -> wdog_err=1 and stays 1 after traffic resumes. Without the macro -> wdog_err=0.

Source files
------------

// File: rtl/noc_inject_arbiter_if.sv
// Injection bundle between flit sources and the router local input port.
// master = arbiter side, slave = requester/router side.
interface noc_inject_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int VC_NUM  = 2,
  parameter int DATA_W  = 16
);
  localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int GNT_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic [1:0]        flit_label;
    logic [VC_W-1:0]   vc_id;
    logic [DATA_W-1:0] data;
  } flit_t;

  logic [NUM_REQ-1:0]  req_valid;
  flit_t [NUM_REQ-1:0] req_flit;
  logic [NUM_REQ-1:0]  req_ready;
  flit_t               router_data_in;
  logic                router_valid_in;
  logic [VC_NUM-1:0]   router_is_on_off_out;
  logic [VC_NUM-1:0]   router_is_allocatable_out;
  logic [GNT_W-1:0]    grant_id;
  logic                grant_busy;
  logic                pkt_done;
  logic                wdog_err;

  modport master (
    input  req_valid, req_flit, router_is_on_off_out, router_is_allocatable_out,
    output req_ready, router_data_in, router_valid_in, grant_id, grant_busy,
           pkt_done, wdog_err
  );

  modport slave (
    output req_valid, req_flit, router_is_on_off_out, router_is_allocatable_out,
    input  req_ready, router_data_in, router_valid_in, grant_id, grant_busy,
           pkt_done, wdog_err
  );
endinterface

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter for one router injection port; holds a grant
// from head to tail and picks the VC at packet start. Optional stall watchdog: NOC_INJ_WDOG_EN.
module noc_inject_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 255,
  parameter int VC_NUM      = 2,
  parameter int DATA_W      = 16
) (
  input  logic                clk_router,
  input  logic                rst_router,
  noc_inject_arbiter_if.master bus
);
  localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int GNT_W = $clog2(NUM_REQ);

  localparam logic [1:0] HEAD     = 2'd0;
  localparam logic [1:0] TAIL     = 2'd2;
  localparam logic [1:0] HEADTAIL = 2'd3;

  typedef struct packed {
    logic [1:0]        flit_label;
    logic [VC_W-1:0]   vc_id;
    logic [DATA_W-1:0] data;
  } flit_t;

  typedef enum logic {IDLE, XFER} state_e;

  state_e             state_q;
  logic [GNT_W-1:0]   last_grant_q, grant_id_q;
  logic [VC_W-1:0]    vc_sel_q;
  logic               busy_q, done_q, vld_q;
  flit_t              data_q;

  flit_t [NUM_REQ-1:0] req_flit;
  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  ready;
  logic [VC_NUM-1:0]   vc_avail;
  logic [VC_W-1:0]     vc_pick;
  logic                vc_found;
  logic [GNT_W-1:0]    rr_pick;
  logic                rr_found;
  logic                on_sel, xfer, fwd_last;
  flit_t               fwd;

  assign req_flit = bus.req_flit;
  assign vc_avail = bus.router_is_on_off_out & bus.router_is_allocatable_out;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
    assign elig[g] = bus.req_valid[g] &&
                     (req_flit[g].flit_label == HEAD || req_flit[g].flit_label == HEADTAIL);
  end

  // Lowest-index VC that is both on and free for a new packet.
  always_comb begin
    vc_pick  = '0;
    vc_found = 1'b0;
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (vc_avail[v]) begin
        vc_pick  = VC_W'(v);
        vc_found = 1'b1;
      end
    end
  end

  // Scan backwards from the farthest offset so the nearest index after last_grant wins.
  always_comb begin
    logic [GNT_W:0] idx;
    rr_pick  = '0;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, last_grant_q} + (GNT_W+1)'(k);
      if (idx >= (GNT_W+1)'(NUM_REQ)) idx = idx - (GNT_W+1)'(NUM_REQ);
      if (elig[idx[GNT_W-1:0]]) begin
        rr_pick  = idx[GNT_W-1:0];
        rr_found = 1'b1;
      end
    end
  end

  assign on_sel = bus.router_is_on_off_out[vc_sel_q];
  assign xfer   = (state_q == XFER) && bus.req_valid[grant_id_q] && on_sel;

  always_comb begin
    ready = '0;
    if (state_q == XFER) ready[grant_id_q] = on_sel;
  end

  always_comb begin
    fwd       = req_flit[grant_id_q];
    fwd.vc_id = vc_sel_q;
  end
  assign fwd_last = (fwd.flit_label == TAIL) || (fwd.flit_label == HEADTAIL);

  always_ff @(posedge clk_router or posedge rst_router) begin
    if (rst_router) begin
      state_q           <= IDLE;
      last_grant_q      <= GNT_W'(NUM_REQ - 1);
      grant_id_q        <= '0;
      vc_sel_q          <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      vld_q             <= 1'b0;
      data_q            <= '0;
      data_q.flit_label <= HEADTAIL;
    end else begin
      done_q <= 1'b0;
      vld_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rr_found && vc_found) begin
            grant_id_q <= rr_pick;
            vc_sel_q   <= vc_pick;
            busy_q     <= 1'b1;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (xfer) begin
            vld_q  <= 1'b1;
            data_q <= fwd;
            if (fwd_last) begin
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              last_grant_q <= grant_id_q;
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready       = ready;
  assign bus.router_data_in  = data_q;
  assign bus.router_valid_in = vld_q;
  assign bus.grant_id        = grant_id_q;
  assign bus.grant_busy      = busy_q;
  assign bus.pkt_done        = done_q;

`ifdef NOC_INJ_WDOG_EN
  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_err_q;

  always_comb begin
    wdog_cnt_d = '0;
    if (state_q == XFER && !xfer)
      wdog_cnt_d = (wdog_cnt_q == 16'hFFFF) ? wdog_cnt_q : wdog_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_router or posedge rst_router) begin
    if (rst_router) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      if (wdog_cnt_d >= 16'(WDOG_CYCLES)) wdog_err_q <= 1'b1;
    end
  end

  assign bus.wdog_err = wdog_err_q;
`else
  // Stays 0 for every legal threshold (1..65535).
  assign bus.wdog_err = (WDOG_CYCLES == 0);
`endif
endmodule
